// File: rtl/swire_pkg.sv
// rtl/swire_pkg.sv - shared S-wire definitions: receiver states, error codes, 38.4 MHz timing defaults
// Ports: none (package).
package swire_pkg;

  typedef enum logic [1:0] {
    WAIT_ARM = 2'd0,
    ARMED    = 2'd1,
    LOW      = 2'd2,
    GAP      = 2'd3
  } swire_state_e;

  localparam logic [1:0] ERR_SHORT = 2'b01;
  localparam logic [1:0] ERR_LONG  = 2'b10;
  localparam logic [1:0] ERR_OVF   = 2'b11;

  // Timing defaults at 38.4 MHz; the transmitter's delay/io_ctrl uses the same values.
  localparam int GLITCH_CYC_DEF  = 4;
  localparam int MIN_LOW_CYC_DEF = 8;
  localparam int MAX_LOW_CYC_DEF = 1536;  // 40 us
  localparam int IDLE_CYC_DEF    = 3840;  // 100 us
  localparam int CNT_W_DEF       = 7;
  localparam int MAX_PULSES_DEF  = 64;

endpackage

// File: rtl/swire_rx_if.sv
// rtl/swire_rx_if.sv - S-wire receiver pin and result bundle
// Signals: i_swire (pin, idle high), o_cnt/o_cnt_valid (burst count strobe),
//          o_err/o_err_code (error strobe and held code), o_busy (burst in progress).
// Modports: master drives the pin and observes results; slave is the receiver.
interface swire_rx_if
  import swire_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();
  logic             i_swire;
  logic [CNT_W-1:0] o_cnt;
  logic             o_cnt_valid;
  logic             o_err;
  logic [1:0]       o_err_code;
  logic             o_busy;

  modport master (output i_swire, input o_cnt, o_cnt_valid, o_err, o_err_code, o_busy);
  modport slave  (input i_swire, output o_cnt, o_cnt_valid, o_err, o_err_code, o_busy);
endinterface

// File: rtl/swire_deglitch.sv
// rtl/swire_deglitch.sv - pin synchroniser plus glitch filter with edge strobes
// Ports: clk, rst_n (async active-low), pin (asynchronous input),
//        level (filtered level), rise/fall (one-cycle strobes, high in the first cycle of the new level).
module swire_deglitch
  import swire_pkg::*;
#(
  parameter int GLITCH_CYC = GLITCH_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int GW = $clog2(GLITCH_CYC + 1);
  localparam logic [GW-1:0] G_LAST = GW'(GLITCH_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic [GW-1:0] gcnt;

  // Both edges see the same 2 + GLITCH_CYC delay, so filtered widths equal pin widths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      gcnt  <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == level) begin
        gcnt <= '0;
      end else if (gcnt == G_LAST) begin
        gcnt  <= '0;
        level <= sync2;
        rise  <= sync2;
        fall  <= ~sync2;
      end else begin
        gcnt <= gcnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/swire_rx.sv
// rtl/swire_rx.sv - S-wire pulse-count receiver: counts legal low pulses per burst, flags errors
// Ports: i_clk_38m (38.4 MHz), i_reset_n (async active-low), bus (swire_rx_if.slave:
//        i_swire in; o_cnt, o_cnt_valid, o_err, o_err_code, o_busy out, all registered).
module swire_rx
  import swire_pkg::*;
#(
  parameter int GLITCH_CYC  = GLITCH_CYC_DEF,
  parameter int MIN_LOW_CYC = MIN_LOW_CYC_DEF,
  parameter int MAX_LOW_CYC = MAX_LOW_CYC_DEF,
  parameter int IDLE_CYC    = IDLE_CYC_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MAX_PULSES  = MAX_PULSES_DEF
) (
  input logic        i_clk_38m,
  input logic        i_reset_n,
  swire_rx_if.slave  bus
);
  localparam int DUR_W = $clog2(IDLE_CYC + 1);

  // dur is cleared by the edge strobe, so in the k-th cycle of a level (k >= 2)
  // it reads k-2; the thresholds below are offset accordingly.
  localparam logic [DUR_W-1:0] DUR_SAT   = DUR_W'(IDLE_CYC);
  localparam logic [DUR_W-1:0] IDLE_HIT  = DUR_W'(IDLE_CYC - 2);
  localparam logic [DUR_W-1:0] SHORT_LIM = DUR_W'(MIN_LOW_CYC - 1);  // at rise, dur = width - 1
  localparam logic [DUR_W-1:0] LONG_HIT  = DUR_W'(MAX_LOW_CYC - 1);  // low for MAX_LOW_CYC + 1 cycles
  localparam logic [CNT_W-1:0] PULSE_MAX = CNT_W'(MAX_PULSES);

  logic             level;
  logic             rise;
  logic             fall;
  logic             edge_any;
  swire_state_e     state;
  logic [DUR_W-1:0] dur;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_valid_q;
  logic             err_q;
  logic [1:0]       err_code_q;
  logic             busy_q;

  swire_deglitch #(.GLITCH_CYC(GLITCH_CYC)) u_deglitch (
    .clk   (i_clk_38m),
    .rst_n (i_reset_n),
    .pin   (bus.i_swire),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  assign edge_any = rise | fall;

  always_ff @(posedge i_clk_38m or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= WAIT_ARM;
      dur         <= '0;
      pcnt        <= '0;
      cnt_q       <= '0;
      cnt_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      cnt_valid_q <= 1'b0;
      err_q       <= 1'b0;

      if (edge_any)
        dur <= '0;
      else if (dur != DUR_SAT)
        dur <= dur + 1'b1;

      // On an edge-strobe cycle dur still holds the previous level's age, so idle
      // checks ignore that cycle.
      case (state)
        WAIT_ARM: begin
          if (level && !edge_any && dur >= IDLE_HIT)
            state <= ARMED;
        end
        ARMED: begin
          if (fall) begin
            state  <= LOW;
            pcnt   <= '0;
            busy_q <= 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            if (dur < SHORT_LIM) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_SHORT;
              state      <= WAIT_ARM;
              busy_q     <= 1'b0;
            end else if (pcnt == PULSE_MAX) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_OVF;
              state      <= WAIT_ARM;
              busy_q     <= 1'b0;
            end else begin
              pcnt  <= pcnt + 1'b1;
              state <= GAP;
            end
          end else if (dur >= LONG_HIT) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_LONG;
            state      <= WAIT_ARM;
            busy_q     <= 1'b0;
          end
        end
        GAP: begin
          if (fall) begin
            state <= LOW;
          end else if (!edge_any && dur >= IDLE_HIT) begin
            cnt_q       <= pcnt;
            cnt_valid_q <= 1'b1;
            state       <= ARMED;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state  <= WAIT_ARM;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_cnt       = cnt_q;
  assign bus.o_cnt_valid = cnt_valid_q;
  assign bus.o_err       = err_q;
  assign bus.o_err_code  = err_code_q;
  assign bus.o_busy      = busy_q;
endmodule
